// File: rtl/chunked_min_scan_controller_pkg.sv
// Shared types and helpers for the chunked minimum-scan controller.
package min_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Address/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_min_scan_controller_lane_min_reducer.sv
// Combinational LANES-wide minimum: binary compare tree over valid lanes, lower lane wins ties.
module lane_min_reducer #(
  parameter int  DATA_WIDTH = 8,
  parameter int  LANES      = 8,
  localparam int LANE_W     = $clog2(LANES)
) (
  input  logic [LANES*DATA_WIDTH-1:0] i_values,
  input  logic [LANES-1:0]            i_valids,
  output logic                        o_any_valid,
  output logic [DATA_WIDTH-1:0]       o_min,
  output logic [LANE_W-1:0]           o_lane
);

  // Heap-ordered tree: node n has children 2n (lower lanes) and 2n+1; leaves at LANES..2*LANES-1.
  logic [DATA_WIDTH-1:0] t_min [1:2*LANES-1];
  logic                  t_vld [1:2*LANES-1];
  logic [LANE_W-1:0]     t_idx [1:2*LANES-1];

  // Reduce leaves up to the root; the right child wins only when strictly lower.
  always_comb begin
    t_min = '{default: '0};
    t_vld = '{default: 1'b0};
    t_idx = '{default: '0};
    for (int k = 0; k < LANES; k++) begin
      t_min[LANES+k] = i_values[k*DATA_WIDTH +: DATA_WIDTH];
      t_vld[LANES+k] = i_valids[k];
      t_idx[LANES+k] = LANE_W'(k);
    end
    for (int n = LANES - 1; n >= 1; n--) begin
      if (t_vld[2*n+1] && (!t_vld[2*n] || (t_min[2*n+1] < t_min[2*n]))) begin
        t_min[n] = t_min[2*n+1];
        t_idx[n] = t_idx[2*n+1];
      end else begin
        t_min[n] = t_min[2*n];
        t_idx[n] = t_idx[2*n];
      end
      t_vld[n] = t_vld[2*n] | t_vld[2*n+1];
    end
    o_any_valid = t_vld[1];
    o_min       = t_min[1];
    o_lane      = t_idx[1];
  end

endmodule

// File: rtl/chunked_min_scan_controller.sv
// Sequenced minimum search over a banked buffer, one word per cycle, result on a valid/ready port.
// Optional MIN_SCAN_EARLY_EXIT_EN: stop issuing reads once the running minimum is a found zero.
module chunked_min_scan_controller
  import min_scan_pkg::*;
#(
  parameter int  DATA_WIDTH     = 8,
  parameter int  TOTAL_CHANNELS = 64,
  parameter int  LANES          = 8,
  localparam int NUM_CHUNKS     = (TOTAL_CHANNELS + LANES - 1) / LANES,
  localparam int ADDR_W         = clog2_min1(NUM_CHUNKS),
  localparam int IDX_WIDTH      = $clog2(TOTAL_CHANNELS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [DATA_WIDTH-1:0]       default_value,
  output logic                        busy,
  output logic                        rd_en,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [LANES*DATA_WIDTH-1:0] rd_values,
  input  logic [LANES-1:0]            rd_valids,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [DATA_WIDTH-1:0]       result_min,
  output logic [IDX_WIDTH-1:0]        result_index,
  output logic                        result_found
);

  localparam int                LANE_W     = $clog2(LANES);
  localparam int                LAST_LANES = TOTAL_CHANNELS - (NUM_CHUNKS - 1) * LANES;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_CHUNKS - 1);

  scan_state_t           r_state;
  logic                  r_busy;
  logic                  r_rd_en;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic                  r_data_vld;
  logic [ADDR_W-1:0]     r_data_chunk;
  logic [DATA_WIDTH-1:0] r_acc_min;
  logic [IDX_WIDTH-1:0]  r_acc_idx;
  logic                  r_acc_found;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_min;
  logic [IDX_WIDTH-1:0]  r_res_idx;
  logic                  r_res_found;

  logic [LANES-1:0]      w_lane_mask;
  logic [LANES-1:0]      w_valids;
  logic                  w_word_any;
  logic [DATA_WIDTH-1:0] w_word_min;
  logic [LANE_W-1:0]     w_word_lane;
  logic [IDX_WIDTH-1:0]  w_word_idx;
  logic                  w_take;
  logic [DATA_WIDTH-1:0] w_next_min;
  logic [IDX_WIDTH-1:0]  w_next_idx;
  logic                  w_next_found;
  logic                  w_early;

  // Lanes past the end of the channel range in the final word never take part.
  always_comb begin
    w_lane_mask = '1;
    for (int k = 0; k < LANES; k++) begin
      if ((r_data_chunk == LAST_ADDR) && (k >= LAST_LANES)) begin
        w_lane_mask[k] = 1'b0;
      end else begin
        w_lane_mask[k] = 1'b1;
      end
    end
  end

  assign w_valids = rd_valids & w_lane_mask;

  lane_min_reducer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_reducer (
    .i_values    (rd_values),
    .i_valids    (w_valids),
    .o_any_valid (w_word_any),
    .o_min       (w_word_min),
    .o_lane      (w_word_lane)
  );

  // Earlier chunks hold lower indices, so strict '<' keeps the lowest index on ties.
  assign w_word_idx   = IDX_WIDTH'({r_data_chunk, w_word_lane});
  assign w_take       = r_data_vld && w_word_any && (w_word_min < r_acc_min);
  assign w_next_min   = w_take ? w_word_min : r_acc_min;
  assign w_next_idx   = w_take ? w_word_idx : r_acc_idx;
  assign w_next_found = r_acc_found | w_take;

`ifdef MIN_SCAN_EARLY_EXIT_EN
  assign w_early = w_next_found && (w_next_min == '0);
`else
  assign w_early = 1'b0;
`endif

  // Job sequencer: read issue, one-cycle data pipeline, accumulator and result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_addr    <= '0;
      r_data_vld   <= 1'b0;
      r_data_chunk <= '0;
      r_acc_min    <= '0;
      r_acc_idx    <= '0;
      r_acc_found  <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_min    <= '0;
      r_res_idx    <= '0;
      r_res_found  <= 1'b0;
    end else begin
      r_data_vld   <= r_rd_en;
      r_data_chunk <= r_rd_addr;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= SCAN;
            r_busy      <= 1'b1;
            r_rd_en     <= 1'b1;
            r_rd_addr   <= '0;
            r_acc_min   <= default_value;
            r_acc_idx   <= '0;
            r_acc_found <= 1'b0;
          end else begin
            r_rd_en <= 1'b0;
          end
        end
        SCAN: begin
          r_acc_min   <= w_next_min;
          r_acc_idx   <= w_next_idx;
          r_acc_found <= w_next_found;
          if ((r_rd_addr == LAST_ADDR) || w_early) begin
            r_rd_en <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          r_acc_min   <= w_next_min;
          r_acc_idx   <= w_next_idx;
          r_acc_found <= w_next_found;
          if (!r_data_vld) begin
            r_state     <= DONE;
            r_res_valid <= 1'b1;
            r_res_min   <= r_acc_min;
            r_res_idx   <= r_acc_found ? r_acc_idx : '0;
            r_res_found <= r_acc_found;
          end else begin
            r_state <= DRAIN;
          end
        end
        DONE: begin
          if (result_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_rd_en     <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign result_valid = r_res_valid;
  assign result_min   = r_res_min;
  assign result_index = r_res_idx;
  assign result_found = r_res_found;

endmodule

// File: tb/tb_chunked_min_scan_controller.sv
// Randomized self-checking bench: a 64-channel and a 60-channel controller scan a shared buffer model.
module tb_chunked_min_scan_controller;

`ifdef MIN_SCAN_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        result_ready;
  logic [7:0]  default_value;
  logic        busy [2];
  logic        rd_en [2];
  logic [2:0]  rd_addr [2];
  logic [63:0] rd_values [2];
  logic [7:0]  rd_valids [2];
  logic        result_valid [2];
  logic [7:0]  result_min [2];
  logic [5:0]  result_index [2];
  logic        result_found [2];

  logic [7:0]  mem_v [64];
  logic        mem_ok [64];

  int n_checks = 0;
  int n_errors = 0;

  chunked_min_scan_controller #(.DATA_WIDTH(8), .TOTAL_CHANNELS(64), .LANES(8)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .start(start), .default_value(default_value),
    .busy(busy[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_values(rd_values[0]),
    .rd_valids(rd_valids[0]), .result_valid(result_valid[0]), .result_ready(result_ready),
    .result_min(result_min[0]), .result_index(result_index[0]), .result_found(result_found[0]));

  chunked_min_scan_controller #(.DATA_WIDTH(8), .TOTAL_CHANNELS(60), .LANES(8)) u_dut60 (
    .clk(clk), .reset_n(reset_n), .start(start), .default_value(default_value),
    .busy(busy[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_values(rd_values[1]),
    .rd_valids(rd_valids[1]), .result_valid(result_valid[1]), .result_ready(result_ready),
    .result_min(result_min[1]), .result_index(result_index[1]), .result_found(result_found[1]));

  always #5 clk = ~clk;

  function automatic logic [63:0] word_v(input logic [2:0] a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = mem_v[int'(a)*8 + k];
    return w;
  endfunction

  function automatic logic [7:0] word_ok(input logic [2:0] a);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[k] = mem_ok[int'(a)*8 + k];
    return w;
  endfunction

  // Buffer model: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (rd_en[0]) begin
      rd_values[0] <= word_v(rd_addr[0]);
      rd_valids[0] <= word_ok(rd_addr[0]);
    end else begin
      rd_values[0] <= {$urandom, $urandom};
      rd_valids[0] <= 8'($urandom);
    end
    if (rd_en[1]) begin
      rd_values[1] <= word_v(rd_addr[1]);
      rd_valids[1] <= word_ok(rd_addr[1]);
    end else begin
      rd_values[1] <= {$urandom, $urandom};
      rd_valids[1] <= 8'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: first strictly-lower valid entry in index order; lc = first chunk ending at a found zero.
  task automatic model(input int tc, input logic [7:0] def, output logic [7:0] m,
                       output logic [5:0] ix, output bit f, output int lc);
    m = def; ix = 6'd0; f = 1'b0; lc = -1;
    for (int i = 0; i < tc; i++) begin
      if (mem_ok[i] && (mem_v[i] < m)) begin
        m = mem_v[i]; ix = 6'(i); f = 1'b1;
      end
      if (((i % 8 == 7) || (i == tc - 1)) && f && (m == 8'd0) && (lc < 0)) lc = i / 8;
    end
  endtask

  task automatic run_job(input logic [7:0] def, input int hold, input bit poke, input bit rdy_early);
    logic [7:0] em [2];
    logic [5:0] ei [2];
    bit         ef [2];
    int         elat [2], enrd [2], lat [2], nrd [2], lc;
    for (int d = 0; d < 2; d++) begin
      model((d == 0) ? 64 : 60, def, em[d], ei[d], ef[d], lc);
      elat[d] = (EARLY && lc >= 0 && lc + 4 < 10) ? lc + 4 : 10;
      enrd[d] = (EARLY && lc >= 0 && lc + 2 < 8) ? lc + 2 : 8;
      lat[d] = -1;
      nrd[d] = 0;
    end
    @(negedge clk);
    default_value = def;
    start = 1'b1;
    result_ready = rdy_early;
    for (int k = 0; k <= 30 && (lat[0] < 0 || lat[1] < 0); k++) begin
      @(negedge clk);
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        if (lat[d] < 0) begin
          if (rd_en[d]) begin
            check("rd_addr", 32'(rd_addr[d]), 32'(nrd[d]));
            nrd[d]++;
          end
          if (result_valid[d]) begin
            lat[d] = k;
            check("latency", 32'(k), 32'(elat[d]));
            check("reads", 32'(nrd[d]), 32'(enrd[d]));
            check("min", 32'(result_min[d]), 32'(em[d]));
            check("index", 32'(result_index[d]), 32'(ei[d]));
            check("found", 32'(result_found[d]), 32'(ef[d]));
          end else begin
            check("busy_run", 32'(busy[d]), 32'd1);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) if (lat[d] < 0) check("timeout", 32'(lat[d]), 32'(elat[d]));
    if (!rdy_early) begin
      for (int h = 0; h < hold; h++) begin
        start = poke;
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
          check("hold_valid", 32'(result_valid[d]), 32'd1);
          check("hold_min", 32'(result_min[d]), 32'(em[d]));
          check("hold_index", 32'(result_index[d]), 32'(ei[d]));
          check("hold_rd_en", 32'(rd_en[d]), 32'd0);
        end
      end
      result_ready = 1'b1;
    end
    @(negedge clk);
    result_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("post_valid", 32'(result_valid[d]), 32'd0);
      check("post_busy", 32'(busy[d]), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_busy"}, 32'(busy[d]), 32'd0);
      check({tag, "_rd_en"}, 32'(rd_en[d]), 32'd0);
      check({tag, "_rd_addr"}, 32'(rd_addr[d]), 32'd0);
      check({tag, "_valid"}, 32'(result_valid[d]), 32'd0);
      check({tag, "_min"}, 32'(result_min[d]), 32'd0);
      check({tag, "_index"}, 32'(result_index[d]), 32'd0);
      check({tag, "_found"}, 32'(result_found[d]), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    result_ready = 1'b0;
    default_value = 8'd0;
    for (int i = 0; i < 64; i++) begin mem_v[i] = 8'd0; mem_ok[i] = 1'b0; end
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Descending values, all valid
    for (int i = 0; i < 64; i++) begin mem_v[i] = 8'(200 - i); mem_ok[i] = 1'b1; end
    run_job(8'd255, 0, 1'b0, 1'b0);

    // Nothing valid: default comes back, not found
    for (int i = 0; i < 64; i++) mem_ok[i] = 1'b0;
    run_job(8'd42, 0, 1'b0, 1'b0);

    // Ties between entries and against default
    for (int i = 0; i < 64; i++) begin mem_v[i] = 8'd9; mem_ok[i] = 1'b1; end
    mem_v[3] = 8'd5;
    mem_v[11] = 8'd5;
    run_job(8'd5, 0, 1'b0, 1'b0);
    run_job(8'd6, 0, 1'b0, 1'b0);

    // Out-of-range lanes of the last word hold zeros flagged valid
    for (int i = 0; i < 64; i++) begin mem_v[i] = (i >= 60) ? 8'd0 : 8'd50; mem_ok[i] = 1'b1; end
    run_job(8'd200, 0, 1'b0, 1'b0);

    // Back-pressure with start pulses while the result waits
    for (int i = 0; i < 64; i++) begin mem_v[i] = 8'($urandom); mem_ok[i] = 1'b1; end
    run_job(8'd128, 5, 1'b1, 1'b0);

    // Zero at index 9: early exit candidate
    for (int i = 0; i < 64; i++) begin mem_v[i] = 8'd100; mem_ok[i] = 1'b1; end
    mem_v[9] = 8'd0;
    run_job(8'd150, 1, 1'b0, 1'b0);

    // Reset while chunk 3 is being read
    for (int i = 0; i < 64; i++) begin mem_v[i] = 8'($urandom_range(1, 255)); mem_ok[i] = 1'b1; end
    @(negedge clk);
    default_value = 8'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_addr", 32'(rd_addr[0]), 32'd3);
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_result", 32'(result_valid[0] | result_valid[1]), 32'd0);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < 64; i++) begin
        mem_v[i] = (j % 2 == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        mem_ok[i] = (j % 3 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      end
      run_job((j % 5 == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), (j % 4 == 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
